// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// load/store data bus. One transfer at a time, registered command, one-cycle
// acks with registered read data, timeout abort with bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  // data port
  input  logic                d_re,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                bus_err,
  // memory side
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                mem_re,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  // core control
  output logic                stall
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER_I = 2'd1,
    ST_XFER_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_d_q, last_d_d;   // 1: data was served last
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                bus_err_q, bus_err_d;

  logic                i_elig;
  logic                d_elig;
  logic                grant_d;
  logic                done;
  logic                timed_out;

  // A port whose ack is high this cycle is not eligible, so a requester that
  // drops its level request after the ack is never served a second time.
  assign i_elig  = i_req & ~i_ack_q;
  assign d_elig  = (d_re | d_we) & ~d_ack_q;
  // Data wins when alone, or on a tie when fetch was served last.
  assign grant_d = d_elig & (~i_elig | ~last_d_q);

  // Next-state, command latch, completion and timeout handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    done        = 1'b0;
    timed_out   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        if (grant_d) begin
          state_d     = ST_XFER_D;
          last_d_d    = 1'b1;
          cnt_d       = '0;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          // Both strobes high is illegal; it is resolved as a write.
          mem_we_d    = d_we;
          mem_re_d    = ~d_we;
        end else if (i_elig) begin
          state_d     = ST_XFER_I;
          last_d_d    = 1'b0;
          cnt_d       = '0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = {BE_W{1'b1}};
          mem_re_d    = 1'b1;
          mem_we_d    = 1'b0;
        end
      end

      ST_XFER_I, ST_XFER_D: begin
        if (mem_ready) begin
          done = 1'b1;
          if (state_q == ST_XFER_I) begin
            i_rdata_d = mem_rdata;
          end else if (mem_re_q) begin
            d_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (done) begin
          state_d   = ST_IDLE;
          mem_re_d  = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = timed_out;
          if (state_q == ST_XFER_I) begin
            i_ack_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without an ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;

  // Freeze the core while a data request waits for grant or is in flight.
  assign stall = (d_re | d_we) & ~d_ack_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between instruction fetch and the load/store data bus. Requests are granted one at a time, and each transfer runs until the memory reports ready or a timeout expires. Each requester receives a one-cycle acknowledge with registered read data. The block sits between the fetch/control sequencing and the external memory, and raises `stall` so the control unit freezes its state machine while a data access is outstanding.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` wide.
- `TIMEOUT`, 15, maximum cycles to wait for `mem_ready` before aborting (≥1).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `i_req` in 1: fetch request, level; held until `i_ack`.
- `i_addr` in ADDR_W: fetch address.
- `i_rdata` out DATA_W: fetched word, valid in the `i_ack` cycle and held until the next fetch ack.
- `i_ack` out 1: one-cycle completion pulse for fetch.
- `d_re` / `d_we` in 1 each: data read/write request, level, mutually exclusive; held until `d_ack`.
- `d_addr` in ADDR_W, `d_wdata` in DATA_W, `d_be` in DATA_W/8: data access fields.
- `d_rdata` out DATA_W: load data, valid in the `d_ack` cycle and held.
- `d_ack` out 1: one-cycle completion pulse for data.
- `bus_err` out 1: one-cycle pulse coincident with an ack that was caused by timeout.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_be` out DATA_W/8, `mem_re` out 1, `mem_we` out 1: memory command.
- `mem_rdata` in DATA_W, `mem_ready` in 1: memory response.
- `stall` out 1: core must hold its state this cycle.

## Operation
- FSM states: IDLE, XFER_I, XFER_D.
- IDLE behaviour:
  - Sample the eligible requests.
  - If both fetch and data are eligible, grant the port that was *not* served last. The last-served flag resets to "fetch", so data wins the first tie.
  - On grant, latch address, wdata, be and direction into command registers, then enter XFER_I or XFER_D.
- Fetch commands always drive `mem_re`=1 and `mem_be`=all ones.
- In XFER_*, `mem_re`/`mem_we` are driven from the latched command; requester inputs are ignored until completion.
- Completion: the first XFER cycle with `mem_ready`=1. Then:
  - capture `mem_rdata` into the matching rdata register (reads only);
  - pulse that port's ack in the next cycle;
  - return to IDLE.
- Timeout: a wait counter of width clog2(TIMEOUT+1) clears on entering XFER and increments each cycle with `mem_ready`=0. When it reaches TIMEOUT, the transfer aborts: ack and `bus_err` pulse next cycle, rdata is left unchanged, and the FSM returns to IDLE.
- Ack-cycle masking: in the cycle its ack is high, a port's request is not eligible for grant, so a requester that drops its request after the ack is never served twice.
- `stall` = (`d_re`|`d_we`) & !`d_ack`. It is combinational and covers a data request that is waiting for grant as well as one in flight.
- `d_re`&`d_we` both high is illegal. If it occurs, treat it as a write.
- Reset, including mid-transfer, has the following effect:
  - FSM goes to IDLE and counter to 0;
  - in-flight transfer abandoned, no ack issued;
  - all registered outputs go to 0 (`mem_*` commands, acks, `bus_err`, rdata registers);
  - last-served flag resets to fetch.

## Timing
- The mem command is registered: a request granted in IDLE at cycle N drives `mem_re`/`mem_we` from cycle N+1.
- Zero-wait memory (`mem_ready`=1 at N+1): ack and rdata at N+2, IDLE at N+2. Minimum latency is 2 cycles.
- Each wait cycle adds 1. With TIMEOUT=T and `mem_ready` never high, ack and `bus_err` are asserted at N+T+2.
- A new grant can be made in the ack cycle (N+2), for the other port only. Back-to-back throughput is one transfer per 2 cycles.
- `mem_re`/`mem_we` are low in IDLE and deassert in the cycle after completion.

## Test plan
- Single fetch: `i_req`=1 with `i_addr`=0x100 at cycle 0, memory ready immediately with 0xDEADBEEF → `mem_re`=1 and `mem_addr`=0x100 at cycle 1; `i_ack`=1 and `i_rdata`=0xDEADBEEF at cycle 2; `stall` stays 0 throughout.
- Store with 2 wait states: `d_we`, `d_addr`=0x2000, `d_wdata`=0x12345678, `d_be`=0x3 → `mem_we` high for cycles 1-3, `mem_ready` at cycle 3, `d_ack` at 4; `stall` is 1 in cycles 0-3 and 0 at cycle 4.
- Simultaneous `i_req` and `d_re` after reset → data granted first. With both requests held, fetch is served next (grant in cycle 2, `i_ack` at 4), and then data is served again.
- Timeout: TIMEOUT=15 and `mem_ready` tied low → `d_ack`=1 and `bus_err`=1 at cycle 17, `d_rdata` unchanged, FSM back in IDLE.
- Ack-cycle masking: requester holds `i_req` one cycle past `i_ack` → no second fetch is issued, and `mem_re` stays 0.
- Reset asserted at cycle 2 of a 4-wait-state load → no `d_ack`; all outputs are 0 in the cycle after the reset edge; a fresh request after release completes normally.
